// File: rtl/prbs9_tx_gen_if.sv
// Output bundle of the PRBS9 transmit pattern source.
// The generator drives it (master); the TX mapper and debug logic read it (slave).
interface prbs9_tx_gen_if #(
    parameter int CNT_W = 64
);
    logic             o_prbs;
    logic             o_prbs_clean;
    logic             o_valid;
    logic             o_inj_ack;
    logic             o_seq_start;
    logic [CNT_W-1:0] o_bits;
    logic [CNT_W-1:0] o_inj_errs;

    modport master (
        output o_prbs,
        output o_prbs_clean,
        output o_valid,
        output o_inj_ack,
        output o_seq_start,
        output o_bits,
        output o_inj_errs
    );

    modport slave (
        input o_prbs,
        input o_prbs_clean,
        input o_valid,
        input o_inj_ack,
        input o_seq_start,
        input o_bits,
        input o_inj_errs
    );
endinterface

// File: rtl/prbs9_tx_gen.sv
// PRBS9 (x^9+x^5+1) transmit pattern source for the I-path BER link test,
// with single-shot and periodic error injection and 64-bit bit/error totals.
module prbs9_tx_gen #(
    parameter logic [8:0] SEED  = 9'h1AA,
    parameter int         CNT_W = 64,
    parameter int         PER_W = 16
) (
    input  logic             clock,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_valid,
    input  logic             i_restart,
    input  logic             i_inj_req,
    input  logic [PER_W-1:0] i_inj_period,
    prbs9_tx_gen_if.master   tx
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;

    logic [8:0]       lfsr;
    logic [PER_W-1:0] per_cnt;
    logic             pend_q;

    logic             emit;
    logic             bit_raw;
    logic             fb;
    logic             pend;
    logic             per_on;
    logic             per_hit;
    logic             inj;

    logic             prbs_q;
    logic             clean_q;
    logic             valid_q;
    logic             ack_q;
    logic             seq_q;
    logic [CNT_W-1:0] bits_q;
    logic [CNT_W-1:0] errs_q;

    // Next state and emission qualifier; restart swallows any strobe
    always_comb begin
        state_nx = state;
        emit     = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_enable) state_nx = RUN;
            end
            RUN: begin
                if (!i_enable) state_nx = PAUSE;
                emit = i_enable & i_valid & ~i_restart;
            end
            PAUSE: begin
                if (i_enable) state_nx = RUN;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Injection decision for the bit emitted this cycle
    always_comb begin
        bit_raw = lfsr[8];
        fb      = lfsr[8] ^ lfsr[4];
        pend    = pend_q | i_inj_req;
        per_on  = |i_inj_period;
        per_hit = per_on && (per_cnt >= (i_inj_period - PER_W'(1)));
        inj     = pend | per_hit;
    end

    // State register; a restart leaves the run state untouched
    always_ff @(posedge clock) begin
        if (i_reset) begin
            state <= IDLE;
        end else if (!i_restart) begin
            state <= state_nx;
        end
    end

    // LFSR: shift on emission, reload on restart
    always_ff @(posedge clock) begin
        if (i_reset) begin
            lfsr <= SEED;
        end else if (i_restart) begin
            lfsr <= SEED;
        end else if (emit) begin
            lfsr <= {lfsr[7:0], fb};
        end
    end

    // Periodic-injection counter; parked at zero while injection is off
    always_ff @(posedge clock) begin
        if (i_reset) begin
            per_cnt <= '0;
        end else if (i_restart || !per_on) begin
            per_cnt <= '0;
        end else if (emit) begin
            if (per_hit) per_cnt <= '0;
            else         per_cnt <= per_cnt + PER_W'(1);
        end
    end

    // Pending single-shot request; repeated requests merge into one flip
    always_ff @(posedge clock) begin
        if (i_reset) begin
            pend_q <= 1'b0;
        end else if (emit) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend;
        end
    end

    // Registered bit outputs; the bit values hold between emissions
    always_ff @(posedge clock) begin
        if (i_reset) begin
            prbs_q  <= 1'b0;
            clean_q <= 1'b0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            seq_q   <= 1'b0;
        end else begin
            valid_q <= emit;
            ack_q   <= emit & pend;
            seq_q   <= emit & (lfsr == SEED);
            if (emit) begin
                prbs_q  <= bit_raw ^ inj;
                clean_q <= bit_raw;
            end
        end
    end

    // Running totals of emitted bits and injected flips, wrapping silently
    always_ff @(posedge clock) begin
        if (i_reset) begin
            bits_q <= '0;
            errs_q <= '0;
        end else if (emit) begin
            bits_q <= bits_q + CNT_W'(1);
            if (inj) errs_q <= errs_q + CNT_W'(1);
        end
    end

    assign tx.o_prbs       = prbs_q;
    assign tx.o_prbs_clean = clean_q;
    assign tx.o_valid      = valid_q;
    assign tx.o_inj_ack    = ack_q;
    assign tx.o_seq_start  = seq_q;
    assign tx.o_bits       = bits_q;
    assign tx.o_inj_errs   = errs_q;

endmodule

// File: doc/prbs9_tx_gen.md
Name: prbs9_tx_gen

Overview:
- Transmit-side pattern source for the BER link test on the I path.
- Generates a PRBS9 bit stream, one bit per symbol strobe, to feed the TX filter/mapper. The receive-side BER counter aligns to this stream and counts errors.
- Provides deterministic error injection: single-shot request or periodic. Keeps 64-bit counts of emitted bits and injected errors so software can cross-check the receiver's reported BER.

Parameters:
- SEED, 9'h1AA, LFSR load value after reset/restart; must be non-zero.
- CNT_W, 64, width of bit and injected-error counters.
- PER_W, 16, width of periodic-injection interval.

Ports:
- clock  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  run enable.
- i_valid  in  1  symbol strobe; one bit emitted per strobe while running.
- i_restart  in  1  pulse; reload SEED, clear period counter; totals kept.
- i_inj_req  in  1  pulse; flip the next emitted bit once.
- i_inj_period  in  PER_W  periodic-injection interval in bits; 0 = disabled.
- o_prbs  out  1  emitted bit, including injected errors.
- o_prbs_clean  out  1  same bit without injection (reference for debug).
- o_valid  out  1  one-cycle strobe qualifying o_prbs/o_prbs_clean.
- o_inj_ack  out  1  one-cycle pulse on the bit that served i_inj_req.
- o_seq_start  out  1  high with o_valid on the first bit of each 511-bit period.
- o_bits  out  CNT_W  total emitted bits.
- o_inj_errs  out  CNT_W  total injected bit flips.

Behaviour:
- Reset (i_reset, synchronous, active-high, clock clock):
  - lfsr=SEED, state=IDLE.
  - All outputs 0, both counters 0.
  - Pending-request flag 0, period counter 0.
- FSM:
  - IDLE->RUN when i_enable=1.
  - RUN->PAUSE when i_enable=0.
  - PAUSE->RUN when i_enable=1.
  - In IDLE and PAUSE: lfsr, counters and pending flag hold; o_valid=0; o_prbs/o_prbs_clean hold last value.
  - An emission happens only in a cycle where state=RUN and i_enable=1 and i_valid=1. The first strobe is accepted one cycle after i_enable rises (IDLE->RUN transition cycle emits nothing).
- LFSR, polynomial x^9+x^5+1:
  - Output bit b=lfsr[8], feedback fb=lfsr[8]^lfsr[4].
  - On emission, lfsr<={lfsr[7:0],fb}.
  - Period is 511; no lock-up state is reachable from a non-zero SEED.
- Emission (registered, latency 1: outputs valid in the cycle after the accepted strobe):
  - o_valid<=1.
  - o_prbs_clean<=b.
  - o_prbs<=b^inj.
  - o_seq_start<=(lfsr==SEED).
  - o_bits<=o_bits+1.
  - In any non-emitting cycle, o_valid, o_inj_ack and o_seq_start are 0.
- Injection decision, evaluated at the emitting cycle:
  - per_hit = (i_inj_period!=0) && (per_cnt>=i_inj_period-1).
  - inj = pend | per_hit, where pend = pending flag OR i_inj_req in the same cycle.
  - Request and periodic hits on the same bit produce one flip: o_inj_errs+1, o_inj_ack=1.
  - If inj=1, o_inj_errs<=o_inj_errs+1.
  - If pend was served, o_inj_ack<=1 and the flag clears.
- Period counter, advancing on emission:
  - per_hit -> 0, else +1.
  - When i_inj_period=0, it is held at 0.
  - Lowering i_inj_period below the current count causes a hit on the next emission (>= compare).
- i_inj_req without an emission sets the pending flag. Further requests while pending are merged (one flip). A request in PAUSE is held until the next emission.
- i_restart, highest priority after reset:
  - Sets lfsr=SEED and per_cnt=0; the current cycle emits nothing.
  - Pending flag, counters and state are unchanged.
  - A simultaneous i_valid strobe is dropped.
- Counters wrap modulo 2^CNT_W silently.
- Reset mid-run overrides everything in that cycle, including an emission.

Test Plan:
- Reset, i_enable=1, 20 strobes, no injection -> first 9 o_prbs bits 1,1,0,1,0,1,0,1,0; o_prbs==o_prbs_clean; o_bits=20; o_inj_errs=0; o_seq_start only on bit 0.
- 1022 strobes -> bits 511..1021 equal bits 0..510; o_seq_start at bits 0 and 511 only; o_bits=1022.
- i_inj_period=100, 1000 strobes -> flips exactly at bit indices 99,199,...,999; o_inj_errs=10; o_inj_ack never asserted.
- i_inj_req pulse with i_valid low, then strobe -> only the next bit flipped, o_inj_ack=1 with it. Request on the same bit as a periodic hit (period=10, bit 9) -> single flip, o_inj_errs+1, ack=1.
- Drop i_enable for 50 cycles mid-run with strobes present -> no o_valid, counters frozen, sequence resumes at the exact next bit. i_restart then sequence restarts at 1,1,0,...; o_bits continues.
- i_reset asserted on a strobe cycle after 300 bits -> o_valid=0 next cycle, counters 0, next emission is bit 0 of the sequence.
